// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, flag bit positions and the
// opcode-to-flag-class helper used by the EX/MEM flag logic.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } opcode_e;

    // Bit positions inside the 3-bit {Z,V,N} flag vector
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    // Which flags an opcode is allowed to write
    typedef enum logic [1:0] {
        FCLS_ZVN  = 2'd0,   // arithmetic: Z, V and N
        FCLS_Z    = 2'd1,   // logic/shift: Z only
        FCLS_NONE = 2'd2    // everything else leaves flags alone
    } flag_class_e;

    function automatic flag_class_e flag_class(input logic [3:0] op);
        flag_class_e cls;
        case (op)
            OP_ADD, OP_SUB:                 cls = FCLS_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = FCLS_Z;
            default:                        cls = FCLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/flag_unit.sv
// Flag unit: holds the architectural {Z,V,N} flags and computes the value
// they take on the next edge. With FLAG_BYPASS_EN defined, that next value
// is also exported as flags_next for same-cycle branch resolution.
module flag_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              ovfl,
    input  logic              update_en,
    output logic [2:0]        flags
`ifdef FLAG_BYPASS_EN
    ,
    output logic [2:0]        flags_next
`endif
);

    logic [2:0] flags_d;

    // Next-flag selection by opcode class; unselected bits hold
    always_comb begin
        flags_d = flags;
        if (update_en) begin
            case (flag_class(opcode))
                FCLS_ZVN: begin
                    flags_d[FLAG_Z] = (result == '0);
                    flags_d[FLAG_V] = ovfl;
                    flags_d[FLAG_N] = result[DATA_W-1];
                end
                FCLS_Z: begin
                    flags_d[FLAG_Z] = (result == '0);
                end
                default: begin
                    flags_d = flags;
                end
            endcase
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            flags <= flags_d;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign flags_next = flags_d;
`endif

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with condition-flag generation.
// Optional feature macro: FLAG_BYPASS_EN (adds the flags_next output).
module ex_mem_flag_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr_en,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [3:0]        mem_opcode,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [2:0]        flags
`ifdef FLAG_BYPASS_EN
    ,
    output logic [2:0]        flags_next
`endif
);

    logic capture;
    logic flag_update;

    // Flush wins over stall; flags move only on a capture of a real instruction
    always_comb begin
        capture     = !stall && !flush;
        flag_update = capture && ex_valid;
    end

    // Pipeline register: flush clears only the control bits, stall holds all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_opcode     <= '0;
            mem_result     <= '0;
            mem_rd         <= '0;
            mem_wr_en      <= 1'b0;
            mem_store_data <= '0;
        end else if (flush) begin
            mem_valid <= 1'b0;
            mem_wr_en <= 1'b0;
        end else if (capture) begin
            mem_valid      <= ex_valid;
            mem_opcode     <= ex_opcode;
            mem_result     <= ex_result;
            mem_rd         <= ex_rd;
            mem_wr_en      <= ex_wr_en && ex_valid;
            mem_store_data <= ex_store_data;
        end
    end

    flag_unit #(
        .DATA_W (DATA_W)
    ) u_flag_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (ex_opcode),
        .result     (ex_result),
        .ovfl       (ex_ovfl),
        .update_en  (flag_update),
        .flags      (flags)
`ifdef FLAG_BYPASS_EN
        ,
        .flags_next (flags_next)
`endif
    );

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboard bench for ex_mem_flag_stage: stimulus pushes hand-computed
// expected stage contents; an independent monitor pops and compares them.
module tb_ex_mem_flag_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic [15:0] ex_store_data;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        mem_wr_en;
    logic [15:0] mem_store_data;
    logic [2:0]  flags;
`ifdef FLAG_BYPASS_EN
    logic [2:0]  flags_next;
`endif

    ex_mem_flag_stage #(
        .DATA_W (16),
        .REG_AW (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_result      (ex_result),
        .ex_ovfl        (ex_ovfl),
        .ex_rd          (ex_rd),
        .ex_wr_en       (ex_wr_en),
        .ex_store_data  (ex_store_data),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_opcode     (mem_opcode),
        .mem_result     (mem_result),
        .mem_rd         (mem_rd),
        .mem_wr_en      (mem_wr_en),
        .mem_store_data (mem_store_data),
        .flags          (flags)
`ifdef FLAG_BYPASS_EN
        ,
        .flags_next     (flags_next)
`endif
    );

    typedef struct {
        int          due;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic [3:0]  rd;
        logic        wr;
        logic [15:0] sd;
        logic [2:0]  fl;
        logic        full;   // 0 after a flush: data fields are don't-care
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".mem_valid"},      32'(mem_valid),      32'd0);
        chk({tag, ".mem_wr_en"},      32'(mem_wr_en),      32'd0);
        chk({tag, ".mem_opcode"},     32'(mem_opcode),     32'd0);
        chk({tag, ".mem_result"},     32'(mem_result),     32'd0);
        chk({tag, ".mem_rd"},         32'(mem_rd),         32'd0);
        chk({tag, ".mem_store_data"}, 32'(mem_store_data), 32'd0);
        chk({tag, ".flags"},          32'(flags),          32'd0);
    endtask

    function automatic exp_t zero_entry();
        exp_t e;
        e.due = 0; e.valid = 1'b0; e.op = '0; e.res = '0; e.rd = '0;
        e.wr = 1'b0; e.sd = '0; e.fl = '0; e.full = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs and push what the stage must show after the edge
    task automatic step(input logic v, input logic [3:0] op, input logic [15:0] res,
                        input logic ov, input logic [3:0] rd, input logic wr,
                        input logic [15:0] sd, input logic st, input logic fl,
                        input logic [2:0] ef);
        exp_t e;
        ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ov;
        ex_rd = rd; ex_wr_en = wr; ex_store_data = sd; stall = st; flush = fl;
        if (fl) begin
            e = held; e.valid = 1'b0; e.wr = 1'b0; e.full = 1'b0; e.fl = ef;
        end else if (st) begin
            e = held; e.fl = ef;
        end else begin
            e.valid = v; e.op = op; e.res = res; e.rd = rd;
            e.wr = wr & v; e.sd = sd; e.fl = ef; e.full = 1'b1;
        end
        e.due = cyc + 1;
        sb.push_back(e);
        held = e;
`ifdef FLAG_BYPASS_EN
        #1;
        chk("flags_next", 32'(flags_next), 32'(ef));
`endif
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every due expectation shortly after the clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("mem_valid", 32'(mem_valid), 32'(e.valid));
                chk("mem_wr_en", 32'(mem_wr_en), 32'(e.wr));
                chk("flags",     32'(flags),     32'(e.fl));
                if (e.full) begin
                    chk("mem_opcode",     32'(mem_opcode),     32'(e.op));
                    chk("mem_result",     32'(mem_result),     32'(e.res));
                    chk("mem_rd",         32'(mem_rd),         32'(e.rd));
                    chk("mem_store_data", 32'(mem_store_data), 32'(e.sd));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_opcode = '0; ex_result = '0; ex_ovfl = 1'b0;
        ex_rd = '0; ex_wr_en = 1'b0; ex_store_data = '0; stall = 1'b0; flush = 1'b0;
        held = zero_entry();
        #2;
        chk_zero("reset_pre_clk");
        #6;
        chk_zero("reset_post_clk");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   v  op     result    ov rd    wr sd        st fl flags
        step(1, 4'h0, 16'h0000, 0, 4'h3, 1, 16'h1234, 0, 0, 3'b100); // ADD zero
        step(1, 4'h1, 16'h8000, 1, 4'h5, 1, 16'h0001, 0, 0, 3'b011); // SUB ovfl, neg
        step(1, 4'h2, 16'h0000, 0, 4'h6, 0, 16'h00FF, 0, 0, 3'b111); // XOR Z only
        step(1, 4'h0, 16'h0005, 0, 4'h7, 1, 16'h0A0A, 0, 0, 3'b000); // ADD positive
        step(1, 4'h0, 16'h4000, 1, 4'h8, 1, 16'h0000, 0, 0, 3'b010); // ADD ovfl
        step(1, 4'h7, 16'h7878, 0, 4'h9, 1, 16'h5555, 0, 0, 3'b010); // PADDSB holds
        step(1, 4'h3, 16'h0000, 0, 4'hA, 1, 16'h0000, 0, 0, 3'b010); // RED holds
        step(1, 4'h8, 16'h0000, 1, 4'hB, 1, 16'hBEEF, 0, 0, 3'b010); // non-ALU holds
        step(0, 4'h0, 16'h0000, 1, 4'hC, 1, 16'h1111, 0, 0, 3'b010); // bubble ADD
        step(1, 4'h4, 16'h0000, 0, 4'hD, 1, 16'h2222, 0, 0, 3'b110); // SLL zero
        step(1, 4'h5, 16'h8001, 0, 4'hE, 1, 16'h3333, 0, 0, 3'b010); // SRA nonzero
        step(1, 4'h6, 16'h0000, 0, 4'hF, 1, 16'h4444, 0, 0, 3'b110); // ROR zero
        step(1, 4'h0, 16'h0000, 1, 4'h1, 0, 16'h9999, 1, 0, 3'b110); // stall 1
        step(1, 4'h1, 16'h8000, 0, 4'h2, 1, 16'h8888, 1, 0, 3'b110); // stall 2
        step(1, 4'h2, 16'h0001, 0, 4'h4, 1, 16'h7777, 1, 0, 3'b110); // stall 3
        step(1, 4'h0, 16'hFFFF, 0, 4'h3, 1, 16'h6666, 1, 1, 3'b110); // stall+flush
        step(1, 4'h1, 16'h8000, 1, 4'h3, 1, 16'h6666, 0, 1, 3'b110); // flush only
        step(1, 4'h0, 16'hFFFF, 0, 4'h2, 1, 16'h0F0F, 0, 0, 3'b001); // ADD negative
        step(1, 4'h0, 16'h0001, 0, 4'h5, 1, 16'h00AA, 0, 0, 3'b000); // ADD 1

        // Asynchronous reset mid-cycle after ADD 0x0001 captured
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_async");
        ex_valid = 1'b1; ex_opcode = 4'h0; ex_result = 16'h0000; ex_ovfl = 1'b1;
        ex_wr_en = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("reset_held_edge");
        #3;
        rst_n = 1'b1;
        held = zero_entry();
        step(1, 4'h1, 16'h8000, 0, 4'h6, 1, 16'h0102, 0, 0, 3'b001); // first capture after reset
        step(1, 4'h0, 16'h0000, 0, 4'h7, 1, 16'h0304, 0, 0, 3'b100);

        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        tests = tests + 1;
        if (sb.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem_flag_stage.md
EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter REG_AW, default 4, register-file address width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid  input  1  execute-stage instruction valid.
REQ-006 SHALL have port ex_opcode  input  4  opcode: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, others non-ALU.
REQ-007 SHALL have port ex_result  input  DATA_W  ALU result, already saturated where applicable.
REQ-008 SHALL have port ex_ovfl  input  1  ALU signed-overflow indication for ADD/SUB.
REQ-009 SHALL have port ex_rd, ex_wr_en, ex_store_data  input  REG_AW/1/DATA_W  destination register, write enable, store data.
REQ-010 SHALL have port stall  input  1  hold stage contents.
REQ-011 SHALL have port flush  input  1  insert bubble.
REQ-012 SHALL have port mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en, mem_store_data  output  1/4/DATA_W/REG_AW/1/DATA_W  registered stage contents.
REQ-013 SHALL have port flags  output  3  registered {Z,V,N}.

Function
REQ-014 SHALL capture all ex_* inputs on rising clk when stall=0 and flush=0; latency exactly 1 cycle.
REQ-015 SHALL hold every mem_* output and flags unchanged when stall=1 and flush=0.
REQ-016 SHALL, when flush=1 (regardless of stall), clear mem_valid and mem_wr_en next edge; other mem_* don't-care; flags unchanged.
REQ-017 SHALL force mem_wr_en=0 whenever captured ex_valid=0.
REQ-018 SHALL update flags only on a capturing edge with ex_valid=1.
REQ-019 SHALL, for ADD/SUB, set Z=(ex_result==0), V=ex_ovfl, N=ex_result[DATA_W-1].
REQ-020 SHALL, for XOR/SLL/SRA/ROR, set Z=(ex_result==0) and hold V,N.
REQ-021 SHALL, for RED, PADDSB and all non-ALU opcodes, hold all three flags.
REQ-022 SHALL treat bubbles (ex_valid=0) as no flag update even if opcode is ADD.

Reset
REQ-023 SHALL, while rst_n=0, drive mem_valid=0, mem_wr_en=0, mem_opcode=0, mem_result=0, mem_rd=0, mem_store_data=0, flags=3'b000, independent of clk.
REQ-024 SHALL, on rst_n assertion mid-operation, discard the in-flight instruction; first capture occurs on first rising clk after deassertion.

Configuration
REQ-025 SHALL, with FLAG_BYPASS_EN defined, add output flags_next (3) equal combinationally to the value flags will take on the next edge, for same-cycle branch resolution.
REQ-026 SHALL, without FLAG_BYPASS_EN, omit flags_next; branch logic consumes only registered flags.

Structure
REQ-027 SHALL place opcode constants, flag bit indices (Z=2,V=1,N=0) and opcode-class helper in shared package cpu_pkg.
REQ-028 SHALL implement flag logic in one sub-module flag_unit (opcode, result, ovfl, update_en -> flags, flags_next); pipeline register in top.

Verification
REQ-029 ADD, ex_result=0x0000, ex_ovfl=0, ex_valid=1 -> next cycle flags=100, mem_result=0x0000, mem_valid=1.
REQ-030 SUB, ex_result=0x8000, ex_ovfl=1 -> flags=011; then XOR, ex_result=0x0000 -> flags=111 (V,N held).
REQ-031 PADDSB, ex_result=0x7878, flags previously 010 -> mem_result=0x7878, flags remain 010.
REQ-032 stall=1 for 3 cycles with changing ex_* -> mem_* and flags frozen; stall=1 with flush=1 -> mem_valid=0, mem_wr_en=0 next edge.
REQ-033 rst_n pulsed low mid-cycle after ADD 0x0001 captured -> all outputs 0 immediately, flags=000.
REQ-034 FLAG_BYPASS_EN defined, ADD 0xFFFF ovfl=0 presented -> flags_next=001 same cycle, flags=001 after edge.
